// File: rtl/kd_tree_pkg.sv
// ============================================================================
// kd_tree_pkg : shared types and constants for the KD-tree node load path
// Rev 1.0
// ============================================================================
`default_nettype none

package kd_tree_pkg;

    localparam int WORD_WIDTH     = 11;
    localparam int INTERNAL_WIDTH = 2 * WORD_WIDTH;
    localparam int ADDR_WIDTH     = 6;
    localparam int NUM_NODES      = 63;
    localparam int MAX_DIM_IDX    = 4;

    // Index field 3'b111 marks the write as a non-node pad entry.
    localparam logic [INTERNAL_WIDTH-1:0] PAD_WORD = 22'h0007FF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_IDX = 3'd1,
        LOAD_MED = 3'd2,
        PAD      = 3'd3,
        DONE     = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/internal_node_loader.sv
// ============================================================================
// internal_node_loader : packs host index/median word pairs into node config
// writes for internal_node_tree, then pads the write address back to 0.
// Rev 1.0
// ============================================================================
`default_nettype none

module internal_node_loader #(
    parameter int NUM_NODES      = kd_tree_pkg::NUM_NODES,
    parameter int ADDR_WIDTH     = kd_tree_pkg::ADDR_WIDTH,
    parameter int WORD_WIDTH     = kd_tree_pkg::WORD_WIDTH,
    parameter int INTERNAL_WIDTH = kd_tree_pkg::INTERNAL_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic                      i_in_valid,
    input  logic [WORD_WIDTH-1:0]     i_in_data,
    output logic                      o_in_ready,
    output logic                      o_fsm_enable,
    output logic                      o_sender_enable,
    output logic [INTERNAL_WIDTH-1:0] o_sender_data,
    output logic                      o_busy,
    output logic                      o_load_done,
    output logic                      o_idx_err,
    output logic [ADDR_WIDTH-1:0]     o_node_count
);
    import kd_tree_pkg::*;

    localparam int PAD_WRITES = (1 << ADDR_WIDTH) - NUM_NODES;
    localparam int PAD_CNT_W  = ADDR_WIDTH + 1;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [WORD_WIDTH-1:0]       r_idx;
    logic [PAD_CNT_W-1:0]        r_pad_cnt;
    logic                        r_fsm_enable;
    logic                        r_sender_enable;
    logic [INTERNAL_WIDTH-1:0]   r_sender_data;
    logic                        r_idx_err;
    logic [ADDR_WIDTH-1:0]       r_node_count;

    logic w_in_ready;
    logic w_start_acc;
    logic w_idx_hs;
    logic w_med_hs;
    logic w_pad_wr;
    logic w_last_node;

    assign w_last_node = (r_node_count == ADDR_WIDTH'(NUM_NODES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_start_acc  = 1'b0;
        w_idx_hs     = 1'b0;
        w_med_hs     = 1'b0;
        w_pad_wr     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_start_acc  = 1'b1;
                    w_next_state = LOAD_IDX;
                end
            end
            LOAD_IDX: begin
                w_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_idx_hs     = 1'b1;
                    w_next_state = LOAD_MED;
                end
            end
            LOAD_MED: begin
                w_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_med_hs = 1'b1;
                    if (w_last_node) begin
                        w_next_state = (PAD_WRITES > 0) ? PAD : DONE;
                    end else begin
                        w_next_state = LOAD_IDX;
                    end
                end
            end
            PAD: begin
                w_pad_wr = 1'b1;
                if (r_pad_cnt == PAD_CNT_W'(PAD_WRITES - 1)) begin
                    w_next_state = DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Emit stage: one registered write per median handshake or pad cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx           <= '0;
            r_pad_cnt       <= '0;
            r_fsm_enable    <= 1'b0;
            r_sender_enable <= 1'b0;
            r_sender_data   <= '0;
            r_idx_err       <= 1'b0;
            r_node_count    <= '0;
        end else begin
            r_sender_enable <= w_med_hs | w_pad_wr;
            if (w_med_hs) begin
                r_sender_data <= {i_in_data, r_idx};
            end else if (w_pad_wr) begin
                r_sender_data <= INTERNAL_WIDTH'(PAD_WORD);
            end

            if (w_idx_hs) begin
                r_idx <= i_in_data;
            end

            if (w_start_acc) begin
                r_node_count <= '0;
                r_idx_err    <= 1'b0;
                r_pad_cnt    <= '0;
                r_fsm_enable <= 1'b1;
            end else begin
                if (w_idx_hs && (i_in_data[2:0] > 3'(MAX_DIM_IDX))) begin
                    r_idx_err <= 1'b1;
                end
                if (w_med_hs && (r_node_count < ADDR_WIDTH'(NUM_NODES))) begin
                    r_node_count <= r_node_count + ADDR_WIDTH'(1);
                end
                if (w_pad_wr) begin
                    r_pad_cnt <= r_pad_cnt + PAD_CNT_W'(1);
                end
                // The first DONE cycle carries the final pad strobe, so drop one cycle later.
                if (r_state == DONE) begin
                    r_fsm_enable <= 1'b0;
                end
            end
        end
    end

    assign o_in_ready      = w_in_ready;
    assign o_fsm_enable    = r_fsm_enable;
    assign o_sender_enable = r_sender_enable;
    assign o_sender_data   = r_sender_data;
    assign o_busy          = (r_state == LOAD_IDX) || (r_state == LOAD_MED) || (r_state == PAD);
    assign o_load_done     = (r_state == DONE);
    assign o_idx_err       = r_idx_err;
    assign o_node_count    = r_node_count;

endmodule

`default_nettype wire

// File: tb/tb_internal_node_loader.sv
// ============================================================================
// tb_internal_node_loader : directed/random load sequences against a write-list model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_internal_node_loader;

    localparam int NN   = 63;
    localparam int AW   = 6;
    localparam int WW   = 11;
    localparam int IW   = 22;
    localparam int NPAD = (1 << AW) - NN;
    localparam logic [IW-1:0] PADW = 22'h0007FF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_in_valid = 1'b0;
    logic [WW-1:0] i_in_data = '0;
    logic          o_in_ready;
    logic          o_fsm_enable;
    logic          o_sender_enable;
    logic [IW-1:0] o_sender_data;
    logic          o_busy;
    logic          o_load_done;
    logic          o_idx_err;
    logic [AW-1:0] o_node_count;

    internal_node_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (i_start),
        .i_in_valid      (i_in_valid),
        .i_in_data       (i_in_data),
        .o_in_ready      (o_in_ready),
        .o_fsm_enable    (o_fsm_enable),
        .o_sender_enable (o_sender_enable),
        .o_sender_data   (o_sender_data),
        .o_busy          (o_busy),
        .o_load_done     (o_load_done),
        .o_idx_err       (o_idx_err),
        .o_node_count    (o_node_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tmo = 0;
    int lat_bad = 0;
    int fsm_bad = 0;
    int hold_bad = 0;
    bit drv_med = 1'b0;
    bit prev_med_hs = 1'b0;
    bit prev_se = 1'b0;
    bit prev_rst = 1'b0;
    logic [IW-1:0] prev_data = '0;
    logic [AW-1:0] wadr = '0;

    logic [IW-1:0] got_q[$];
    logic [IW-1:0] exp_q[$];
    logic [WW-1:0] idx_w[NN];
    logic [WW-1:0] med_w[NN];
    bit exp_err;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) wadr <= '0;
        else if (o_sender_enable) wadr <= wadr + AW'(1);
    end

    // Observes the write port: collects strobes and protocol violations.
    always @(negedge clk) begin
        if (o_sender_enable) begin
            got_q.push_back(o_sender_data);
            if (!o_fsm_enable) fsm_bad++;
            if (!(prev_med_hs || (prev_se && o_sender_data === PADW))) lat_bad++;
        end
        if (prev_med_hs && !o_sender_enable) lat_bad++;
        if (rst_n && prev_rst && !o_sender_enable && o_sender_data !== prev_data) hold_bad++;
        prev_med_hs = rst_n && i_in_valid && o_in_ready && drv_med;
        prev_se     = o_sender_enable;
        prev_data   = o_sender_data;
        prev_rst    = rst_n;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic drive_word(input logic [WW-1:0] w, input bit med, input int gap_max, input bit stray);
        int g;
        int n;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        i_in_valid = 1'b0;
        repeat (g) step();
        i_in_valid = 1'b1;
        i_in_data  = w;
        drv_med    = med;
        i_start    = stray && ($urandom_range(3, 0) == 0);
        n = 0;
        while (!o_in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) tmo++;
        step();
        i_in_valid = 1'b0;
        i_start    = 1'b0;
        drv_med    = 1'b0;
    endtask

    task automatic fill_directed();
        for (int n = 0; n < NN; n++) begin
            idx_w[n] = WW'(n % 5);
            med_w[n] = WW'(n - 31);
        end
    endtask

    task automatic fill_random(input int err_node);
        for (int n = 0; n < NN; n++) begin
            idx_w[n] = (WW'($urandom) & 11'h7F8) | WW'($urandom_range(4, 0));
            med_w[n] = WW'($urandom);
            if (n == err_node) idx_w[n] = 11'd6;
        end
    endtask

    task automatic build_model();
        exp_q.delete();
        exp_err = 1'b0;
        for (int n = 0; n < NN; n++) begin
            exp_q.push_back({med_w[n], idx_w[n]});
            if (idx_w[n][2:0] > 3'd4) exp_err = 1'b1;
        end
        repeat (NPAD) exp_q.push_back(PADW);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_wr%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic run_load(input string tag, input int gap_max, input bit stray);
        int t0;
        int n;
        build_model();
        got_q.delete();
        pulse_start();
        t0 = cyc;
        chk({tag, "_fsm_rise"}, o_fsm_enable, 1);
        chk({tag, "_busy"}, o_busy, 1);
        chk({tag, "_cnt_clr"}, o_node_count, 0);
        chk({tag, "_err_clr"}, o_idx_err, 0);
        for (int k = 0; k < NN; k++) begin
            drive_word(idx_w[k], 1'b0, gap_max, stray);
            drive_word(med_w[k], 1'b1, gap_max, stray);
        end
        if (stray) begin
            chk({tag, "_in_pad"}, o_busy, 1);
            i_start = 1'b1;
            step();
            i_start = 1'b0;
        end
        n = 0;
        while (!o_load_done && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_done_tmo"}, (n < 100), 1);
        if (gap_max == 0 && !stray) chk({tag, "_cycles"}, cyc - t0, 2 * NN + NPAD);
        chk({tag, "_node_count"}, o_node_count, NN);
        chk({tag, "_idx_err"}, o_idx_err, exp_err);
        step();
        chk({tag, "_fsm_fall"}, o_fsm_enable, 0);
        repeat (3) step();
        chk({tag, "_done_hold"}, o_load_done, 1);
        chk({tag, "_not_busy"}, o_busy, 0);
        chk({tag, "_no_ready"}, o_in_ready, 0);
        chk({tag, "_err_sticky"}, o_idx_err, exp_err);
        chk({tag, "_wadr_wrap"}, wadr, 0);
        check_writes(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, o_in_ready, 0);
        chk({tag, "_fsm_en"}, o_fsm_enable, 0);
        chk({tag, "_snd_en"}, o_sender_enable, 0);
        chk({tag, "_snd_data"}, o_sender_data, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_load_done, 0);
        chk({tag, "_idx_err"}, o_idx_err, 0);
        chk({tag, "_node_cnt"}, o_node_count, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        check_reset_outputs("rst0");
        rst_n = 1'b1;
        step();
        chk("idle_hold", o_busy, 0);

        // Directed load, back-to-back words.
        fill_directed();
        run_load("dir", 0, 1'b0);
        chk("node0_data", got_q.size() > 0 ? 32'(got_q[0]) : 32'hDEAD, 32'h3F0800);
        chk("node62_data", got_q.size() > 62 ? 32'(got_q[62]) : 32'hDEAD, 32'({11'd31, 11'd2}));
        chk("pad_data", got_q.size() > 63 ? 32'(got_q[63]) : 32'hDEAD, 32'(PADW));

        // Same data from DONE with host gaps and stray start pulses.
        run_load("gap", 3, 1'b1);

        // Random data with a bad index on node 5.
        fill_random(5);
        run_load("err", 2, 1'b0);
        chk("node5_idx", got_q.size() > 5 ? 32'(got_q[5][2:0]) : 32'hDEAD, 32'd6);

        // Partial load aborted by reset after node 10.
        fill_random(-1);
        pulse_start();
        chk("rel_err_clr", o_idx_err, 0);
        for (int k = 0; k <= 10; k++) begin
            drive_word(idx_w[k], 1'b0, 1, 1'b0);
            drive_word(med_w[k], 1'b1, 1, 1'b0);
        end
        chk("abort_strobe", o_sender_enable, 1);
        chk("abort_data", o_sender_data, {med_w[10], idx_w[10]});
        chk("abort_cnt", o_node_count, 11);
        rst_n = 1'b0;
        step();
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;
        step();

        fill_random(-1);
        run_load("reload", 0, 1'b0);

        chk("tmo", tmo, 0);
        chk("lat_bad", lat_bad, 0);
        chk("fsm_bad", fsm_bad, 0);
        chk("hold_bad", hold_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/internal_node_loader.md
Name: internal_node_loader

Overview:
- Transmitter side of the KD-tree internal-node write port.
- Accepts a host stream of 11-bit words, two per node: a dimension-index word, then a median word.
- Packs each pair into the 22-bit node config word and drives fsm_enable / sender_enable / sender_data into internal_node_tree, in node order 0..NUM_NODES-1.
- After the last node it issues pad writes so the tree's write-address counter wraps to 0. This allows a reload without reset.

Parameters:
- NUM_NODES, 63, internal nodes to load (6-level tree, nodes 0..62).
- ADDR_WIDTH, 6, width of the tree's write-address counter. Pad writes = 2**ADDR_WIDTH - NUM_NODES.
- WORD_WIDTH, 11, host word width; also the index and median field width.
- INTERNAL_WIDTH, 22, packed config width (2*WORD_WIDTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a load from IDLE or DONE
- in_valid  in  1  host word valid
- in_data  in  WORD_WIDTH  host word: index word, then median word (signed), alternating
- in_ready  out  1  loader accepts a word this cycle
- fsm_enable  out  1  write phase active; to tree fsm_enable
- sender_enable  out  1  one-cycle write strobe per node or pad write
- sender_data  out  INTERNAL_WIDTH  {median[10:0], index_word[10:0]}; index in bits [2:0]
- busy  out  1  state is LOAD_IDX, LOAD_MED or PAD
- load_done  out  1  state is DONE
- idx_err  out  1  sticky: some index word had bits [2:0] > 4
- node_count  out  ADDR_WIDTH  nodes written in the current load

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE.
  - All outputs 0: in_ready, fsm_enable, sender_enable, sender_data, busy, load_done, idx_err, node_count. Internal pad counter also 0.
  - Reset mid-load abandons the load. The tree shares rst_n, so both ends realign to address 0.
- States:
  - IDLE:
    - in_ready=0.
    - start -> LOAD_IDX; node_count cleared; idx_err cleared.
  - LOAD_IDX:
    - in_ready=1.
    - On in_valid&&in_ready: capture in_data into idx_reg; set idx_err if in_data[2:0]>4. The word is still forwarded unchanged.
    - Then -> LOAD_MED.
  - LOAD_MED:
    - in_ready=1.
    - On handshake: next cycle sender_data={in_data, idx_reg} and sender_enable=1 for exactly one cycle; node_count increments.
    - If this was node NUM_NODES-1 -> PAD, else -> LOAD_IDX.
  - PAD:
    - in_ready=0.
    - Issues 2**ADDR_WIDTH-NUM_NODES writes (default 1) on consecutive cycles, directly after the last node write, with sender_data = 22'h0007FF (index field 3'b111, invalid).
    - After the last pad write -> DONE.
  - DONE:
    - load_done=1, in_ready=0.
    - start -> LOAD_IDX, clearing node_count and idx_err.
- Latency: median handshake at cycle N -> sender_enable at N+1. sender_data and sender_enable are registered.
- fsm_enable:
  - Registered.
  - Rises the cycle after start is accepted.
  - Stays high through the cycle carrying the last pad write.
  - Is high in every cycle sender_enable is high.
- Host gaps (in_valid=0) insert idle cycles: no sender_enable, and state and idx_reg hold.
- No backpressure from the tree; one write per cycle maximum.
- Back-to-back host words give one node write every 2 cycles.
- start is ignored while busy or in the same cycle as any handshake.
- sender_data holds its last value when sender_enable=0.
- node_count saturates at NUM_NODES; it is not wrapped by pad writes.

Decomposition:
- Shared package kd_tree_pkg:
  - state enum {IDLE, LOAD_IDX, LOAD_MED, PAD, DONE};
  - INTERNAL_WIDTH, WORD_WIDTH, ADDR_WIDTH, NUM_NODES, MAX_DIM_IDX=4, PAD_WORD=22'h0007FF.
  - Shared with internal_node_tree.
- Single module, no sub-module. The pack and emit register stage is inline.

Test Plan:
- Full load, back-to-back words, node n: index=n%5, median=n-31 -> 63 strobes.
  - Node 0 data 22'h3F0800.
  - Node 62 data {11'd31, 11'd2}.
  - Then one pad strobe 22'h0007FF.
  - load_done=1, node_count=63, idx_err=0.
- Same load with random in_valid gaps -> identical write sequence; no extra strobes; strobe always one cycle after a median handshake.
- Node 5 index word 11'd6 -> idx_err=1 and stays high through DONE; node 5 data[2:0]=3'b110; cleared on next start.
- rst_n=0 after node 10 written -> next cycle all outputs 0, state IDLE; new start reloads from node 0.
- In DONE, start plus a second 63-node load -> 64 more strobes. A connected internal_node_tree receives node 0 data at node 0 (wadr wrapped to 0).
- start pulses during LOAD_MED and PAD -> ignored; sequence and node_count unaffected.
